lab2_exerciser: RTL and testbench
=================================

# lab2_exerciser

Self-checking stimulus/response engine for the `lab2` gate network, used for on-board bring-up.
- On a start pulse, it drives the `lab2` inputs a, b, c through all eight combinations.
- It holds each vector for a programmable settle time, then samples the `lab2` outputs x, y.
- It compares each sample against a built-in golden model and reports mismatch count, first failing vector and pass/fail.
- It sits between board buttons/LEDs and the `lab2` instance.

## Interface
Parameters:
- HOLD_CYCLES, 4, cycles each vector is driven before x/y are compared; legal range 1..255
- CNT_W, 4, width of err_count; must hold 8

Ports:
- clk  in  1  single system clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  level sampled each edge; high in IDLE or DONE begins a sweep
- drive_a, drive_b, drive_c  out  1 each  stimulus to `lab2` inputs a, b, c
- dut_x, dut_y  in  1 each  `lab2` outputs x, y
- busy  out  1  high while a sweep is in progress
- done  out  1  high in DONE; held until the next start or reset
- pass  out  1  done && err_count==0
- err_count  out  CNT_W  number of mismatching vectors in the last sweep
- first_fail_vec  out  3  {a,b,c} of the first mismatching vector; 0 if none
- first_fail_xy  out  2  {x_bad,y_bad} for first_fail_vec; 0 if none

## Operation
- Golden model:
  - x_exp = ~c ^ (a|b)
  - y_exp = a & b
- Vector index vec[2:0] = {a,b,c}; sweep order is 0→7; drive_* = vec bits while busy, else 0.
- State machine IDLE, DRIVE, DONE:
  - IDLE: busy=0, done=0. start=1 → DRIVE with vec=0, hold counter=0, err_count and first_fail_* cleared.
  - DRIVE: busy=1. The hold counter increments each cycle. On the cycle where counter==HOLD_CYCLES-1:
    - compare dut_x/dut_y against the golden model for vec;
    - on mismatch, err_count+1; if this is the first mismatch, latch vec into first_fail_vec and {x_bad,y_bad} into first_fail_xy;
    - if vec==7 → DONE; else vec+1 and counter=0.
  - DONE: busy=0, done=1, results held. start=1 → new sweep, as from IDLE.
- start while busy is ignored; no restart or abort.
- err_count cannot exceed 8; no saturation logic is required.

## Timing
- Reset (asynchronous assert, synchronous deassert by system): state=IDLE and every output =0, i.e. drive_*, busy, done, pass, err_count, first_fail_vec, first_fail_xy.
- Reset during DRIVE aborts immediately; results are lost.
- Start accepted at edge E0: drive_* = vec 0 and busy=1 visible after E0.
- Comparison for vector k happens at edge E0 + (k+1)·HOLD_CYCLES. dut_x/dut_y are sampled at that edge, i.e. after HOLD_CYCLES cycles of stable stimulus.
- done=1 and busy=0 after edge E0 + 8·HOLD_CYCLES. With HOLD_CYCLES=4: 32 cycles.
- pass and err_count are valid in the same cycle done rises.
- HOLD_CYCLES=1: one vector per cycle; the DUT must settle within one clock.

## Configuration
- LAB2_EXER_STOP_ON_FAIL_EN defined:
  - the first mismatch ends the sweep at that comparison edge → DONE;
  - err_count=1, first_fail_* latched, and drive_* return to 0.
- Undefined (default): all eight vectors are always applied and counted.

## Structure
- Package lab2_exer_pkg holds:
  - state enum (IDLE, DRIVE, DONE);
  - NUM_VECTORS=8 constant;
  - vec index typedef (logic [2:0]).
- Sub-module lab2_golden: combinational a,b,c → x_exp, y_exp. It is instantiated once here and reused by the testbench as the scoreboard.
- Remaining logic (FSM, hold counter, result registers) lives in lab2_exerciser.

## Test plan
- Correct `lab2` attached, HOLD_CYCLES=4, 1-cycle start pulse:
  - → busy for 32 cycles, then done=1, pass=1, err_count=0, first_fail_vec=0, first_fail_xy=0.
- dut_y stuck at 0:
  - → err_count=2 (vectors 6, 7), first_fail_vec=3'b110, first_fail_xy=2'b01, pass=0.
- dut_x inverted:
  - → err_count=8, first_fail_vec=0, first_fail_xy=2'b10.
- rst_n pulled low while vec=3 is driven:
  - → all outputs 0 immediately, state IDLE;
  - a new start produces a full clean sweep.
- start held high throughout a sweep:
  - → no restart mid-sweep;
  - a new sweep begins on the edge after done rises, with results cleared.
- With LAB2_EXER_STOP_ON_FAIL_EN and dut_y stuck at 0:
  - → done at edge E0+28, err_count=1, first_fail_vec=3'b110.

Source files
------------

// File: rtl/lab2_exer_pkg.sv
// Shared types and constants for the lab2 stimulus/response exerciser.
// Holds the FSM state encoding, the vector count and the {a,b,c} index type.
package lab2_exer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int NUM_VECTORS = 8;

  typedef logic [2:0] vec_t;

  localparam vec_t LAST_VEC = vec_t'(NUM_VECTORS - 1);

endpackage

// File: rtl/lab2_golden.sv
// Golden model of the lab2 gate network: x = ~c ^ (a|b), y = a & b.
// Purely combinational, zero latency; no flow control.
module lab2_golden (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic x_exp,
  output logic y_exp
);

  always_comb begin
    x_exp = ~c ^ (a | b);
    y_exp = a & b;
  end

endmodule

// File: rtl/lab2_exerciser.sv
// Sweeps lab2 through all 8 {a,b,c} vectors, holding each HOLD_CYCLES before checking x/y.
// Sweep takes 8*HOLD_CYCLES cycles; start is ignored while busy; LAB2_EXER_STOP_ON_FAIL_EN ends on first mismatch.
module lab2_exerciser
  import lab2_exer_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             drive_a,
  output logic             drive_b,
  output logic             drive_c,
  input  logic             dut_x,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [2:0]       first_fail_vec,
  output logic [1:0]       first_fail_xy
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_e             state_q, state_d;
  vec_t               vec_q, vec_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [CNT_W-1:0]   err_count_q, err_count_d;
  vec_t               first_fail_vec_q, first_fail_vec_d;
  logic [1:0]         first_fail_xy_q, first_fail_xy_d;

  logic x_exp, y_exp;
  logic x_bad, y_bad, mismatch, at_cmp;

  lab2_golden u_golden (
    .a     (vec_q[2]),
    .b     (vec_q[1]),
    .c     (vec_q[0]),
    .x_exp (x_exp),
    .y_exp (y_exp)
  );

  always_comb begin
    x_bad    = dut_x ^ x_exp;
    y_bad    = dut_y ^ y_exp;
    mismatch = x_bad | y_bad;
    at_cmp   = (state_q == DRIVE) && (cnt_q == HOLD_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      vec_q            <= '0;
      cnt_q            <= '0;
      err_count_q      <= '0;
      first_fail_vec_q <= '0;
      first_fail_xy_q  <= '0;
    end else begin
      state_q          <= state_d;
      vec_q            <= vec_d;
      cnt_q            <= cnt_d;
      err_count_q      <= err_count_d;
      first_fail_vec_q <= first_fail_vec_d;
      first_fail_xy_q  <= first_fail_xy_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    vec_d            = vec_q;
    cnt_d            = cnt_q;
    err_count_d      = err_count_q;
    first_fail_vec_d = first_fail_vec_q;
    first_fail_xy_d  = first_fail_xy_q;
    case (state_q)
      IDLE, DONE: begin
        // A new sweep wipes the previous sweep's results.
        if (start) begin
          state_d          = DRIVE;
          vec_d            = '0;
          cnt_d            = '0;
          err_count_d      = '0;
          first_fail_vec_d = '0;
          first_fail_xy_d  = '0;
        end
      end
      DRIVE: begin
        if (at_cmp) begin
          if (mismatch) begin
            err_count_d = err_count_q + CNT_W'(1);
            if (err_count_q == '0) begin
              first_fail_vec_d = vec_q;
              first_fail_xy_d  = {x_bad, y_bad};
            end
          end
`ifdef LAB2_EXER_STOP_ON_FAIL_EN
          if ((vec_q == LAST_VEC) || mismatch) begin
`else
          if (vec_q == LAST_VEC) begin
`endif
            state_d = DONE;
          end else begin
            vec_d = vec_q + 3'd1;
            cnt_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy           = (state_q == DRIVE);
    done           = (state_q == DONE);
    pass           = done && (err_count_q == '0);
    drive_a        = busy & vec_q[2];
    drive_b        = busy & vec_q[1];
    drive_c        = busy & vec_q[0];
    err_count      = err_count_q;
    first_fail_vec = first_fail_vec_q;
    first_fail_xy  = first_fail_xy_q;
  end

endmodule

// File: tb/tb_lab2_exerciser.sv
// Bench for lab2_exerciser: an emulated lab2 with per-vector fault injection,
// checked against a sweep-level reference model of the expected results.
module tb_lab2_exerciser;

  localparam int H = 4;
`ifdef LAB2_EXER_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       drive_a, drive_b, drive_c;
  logic       dut_x, dut_y;
  logic       busy, done, pass;
  logic [3:0] err_count;
  logic [2:0] first_fail_vec;
  logic [1:0] first_fail_xy;

  logic [7:0] flip_x, flip_y;
  logic [2:0] dv;

  int errors = 0;
  int checks = 0;

  lab2_exerciser #(.HOLD_CYCLES(H), .CNT_W(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .drive_a        (drive_a),
    .drive_b        (drive_b),
    .drive_c        (drive_c),
    .dut_x          (dut_x),
    .dut_y          (dut_y),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_fail_vec (first_fail_vec),
    .first_fail_xy  (first_fail_xy)
  );

  always #5 clk = ~clk;

  // Emulated lab2: x is 1 exactly when (a|b) equals c, y is a AND b; flips inject faults.
  assign dv = {drive_a, drive_b, drive_c};
  always_comb begin
    dut_x = (((dv[2] | dv[1]) == dv[0]) ? 1'b1 : 1'b0) ^ flip_x[dv];
    dut_y = (dv[2] & dv[1]) ^ flip_y[dv];
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Runs one sweep from IDLE/DONE; with hold_start the start line stays high throughout.
  task automatic run_sweep(input string tag, input bit hold_start);
    int exp_err, exp_ffv, exp_ffxy, last_vec, n;
    bit stopped;
    exp_err = 0; exp_ffv = 0; exp_ffxy = 0; last_vec = 7; stopped = 1'b0;
    for (int v = 0; v < 8; v++) begin
      if (!stopped && (flip_x[v] || flip_y[v])) begin
        if (exp_err == 0) begin
          exp_ffv  = v;
          exp_ffxy = {30'd0, flip_x[v], flip_y[v]};
        end
        exp_err++;
        if (STOP) begin
          last_vec = v;
          stopped  = 1'b1;
        end
      end
    end

    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold_start) start = 1'b0;
    check_val({tag, ".busy_after_start"}, 32'(busy), 32'd1);
    n = 0;
    while (busy && n < 2000) begin
      if (dv !== 3'(n / H)) check_val({tag, ".drive_seq"}, 32'(dv), 32'(n / H));
      @(posedge clk);
      #1;
      n++;
    end
    check_val({tag, ".sweep_cycles"}, 32'(n), 32'((last_vec + 1) * H));
    check_val({tag, ".done"}, 32'(done), 32'd1);
    check_val({tag, ".pass"}, 32'(pass), 32'(exp_err == 0));
    check_val({tag, ".err_count"}, 32'(err_count), 32'(exp_err));
    check_val({tag, ".first_fail_vec"}, 32'(first_fail_vec), 32'(exp_ffv));
    check_val({tag, ".first_fail_xy"}, 32'(first_fail_xy), 32'(exp_ffxy));
    check_val({tag, ".drive_idle"}, 32'(dv), 32'd0);

    if (hold_start) begin
      @(posedge clk);
      #1;
      check_val({tag, ".restart_busy"}, 32'(busy), 32'd1);
      check_val({tag, ".restart_cleared"}, 32'({done, err_count, first_fail_vec, first_fail_xy}), 32'd0);
      start = 1'b0;
      n = 0;
      while (!done && n < 2000) begin
        @(posedge clk);
        #1;
        n++;
      end
      check_val({tag, ".restart_finished"}, 32'(done), 32'd1);
    end
  endtask

  function automatic logic [31:0] all_outputs();
    return 32'({drive_a, drive_b, drive_c, busy, done, pass, err_count, first_fail_vec, first_fail_xy});
  endfunction

  initial begin
    int n;
    rst_n  = 1'b0;
    start  = 1'b0;
    flip_x = 8'h00;
    flip_y = 8'h00;
    #12;
    check_val("reset_outputs", all_outputs(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_val("idle_outputs", all_outputs(), 32'd0);

    run_sweep("clean", 1'b0);

    flip_x = 8'h00; flip_y = 8'hC0;
    run_sweep("y_stuck0", 1'b0);

    flip_x = 8'hFF; flip_y = 8'h00;
    run_sweep("x_inverted", 1'b0);

    // Reset while vector 3 is on the bus.
    flip_x = 8'h00; flip_y = 8'h00;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (dv != 3'd3 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val("reach_vec3", 32'(dv), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_sweep_reset", all_outputs(), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_val("held_reset", all_outputs(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep("after_reset", 1'b0);

    flip_x = 8'h00; flip_y = 8'hC0;
    run_sweep("start_held", 1'b1);

    for (int i = 0; i < 6; i++) begin
      flip_x = 8'($urandom) & 8'($urandom);
      flip_y = 8'($urandom) & 8'($urandom);
      run_sweep($sformatf("rand%0d", i), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
